// File: rtl/fetch_controller_pkg.sv
// Shared state encoding, default parameters and address helpers for the
// instruction fetch stage.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'b00,
        FETCH      = 2'b01,
        STALLED    = 2'b10,
        HALT       = 2'b11
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD  = 32'hFFFF_FFFF;
    localparam int unsigned DEFAULT_IMEM_WORDS = 1024;
    localparam logic [31:0] PC_STEP            = 32'd4;

    // True when the word index of a byte address lies beyond the memory depth.
    function automatic logic word_out_of_range(input logic [31:0] addr,
                                               input int unsigned words);
        return {2'b00, addr[31:2]} >= 32'(words);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_controller_if_id_reg.sv
// IF/ID pipeline register with hold enable and a synchronous squash that
// takes priority over the load.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] d_instruction,
    input  logic [31:0] d_pcplus4,
    input  logic        d_valid,
    output logic [31:0] instruction,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= 32'h0;
            pcplus4     <= 32'h0;
            valid       <= 1'b0;
        end else if (clear) begin
            instruction <= 32'h0;
            pcplus4     <= 32'h0;
            valid       <= 1'b0;
        end else if (enable) begin
            instruction <= d_instruction;
            pcplus4     <= d_pcplus4;
            valid       <= d_valid;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC register, fetch FSM, address checking and the
// fetch counter, feeding the IF/ID register.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD,
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        addr_error,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         is_halt_word;
    logic         take_redirect;
    logic         advance;

    assign pc_plus4     = pc + PC_STEP;
    assign imem_address = pc;
    assign is_halt_word = (imem_instruction == HALT_WORD);

    // The hold cycle after reset ignores redirects; a stalled fetch resumes on
    // the same edge stall drops, so decode never sees a duplicated word.
    always_comb begin
        take_redirect = redirect && (state != RESET_HOLD);
        advance       = !take_redirect && !stall &&
                        ((state == FETCH) || (state == STALLED));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_HOLD;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            addr_error  <= 1'b0;
            fetch_count <= 32'h0;
        end else if (take_redirect) begin
            state  <= FETCH;
            pc     <= align_word(redirect_target);
            halted <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                addr_error <= 1'b1;
            end
        end else if (advance) begin
            if (word_out_of_range(pc, IMEM_WORDS)) begin
                addr_error <= 1'b1;
            end
            if (is_halt_word) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                state       <= FETCH;
                pc          <= pc_plus4;
                fetch_count <= fetch_count + 32'd1;
            end
        end else begin
            case (state)
                RESET_HOLD:     state <= FETCH;
                FETCH, STALLED: state <= STALLED;
                HALT:           state <= HALT;
                default:        state <= RESET_HOLD;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (advance),
        .clear         (take_redirect),
        .d_instruction (imem_instruction),
        .d_pcplus4     (pc_plus4),
        .d_valid       (!is_halt_word),
        .instruction   (ifid_instruction),
        .pcplus4       (ifid_pcplus4),
        .valid         (ifid_valid)
    );

endmodule
